// File: rtl/dynode_pulsegen.sv
// Synthetic dynode pulse source: timed ramp, peak and exponential tail on a 12-bit stream.
// Optional LFSR noise on the output is enabled with `define DYNODE_PULSEGEN_NOISE_EN.
module dynode_pulsegen #(
    parameter int DECAY_SHIFT = 2,
    parameter int TAIL_MIN    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  timcnt,
    input  logic        start,
    input  logic [7:0]  tgt_tim,
    input  logic [3:0]  tgt_frac,
    input  logic [7:0]  amp,
    output logic [11:0] dyn_sim,
    output logic        busy,
    output logic        done,
    output logic        start_rej,
    output logic [11:0] exp_tim
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_RISE  = 3'd2;
    localparam logic [2:0] S_PEAK  = 3'd3;
    localparam logic [2:0] S_DECAY = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  tim_q, tim_d;
    logic [3:0]  frac_q, frac_d;
    logic [7:0]  amp_q, amp_d;
    logic [11:0] y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rej_q, rej_d;
    logic [11:0] exp_q, exp_d;

    // Ramp sample k: amp * (16*(k+1) - frac) / 4
    logic [6:0]  slot;
    logic [13:0] prod;
    logic [11:0] ramp;
    logic [11:0] peak;

    assign slot = 7'd16 + {1'b0, k_q, 4'b0000} - {3'b000, frac_q};
    assign prod = 14'(amp_q) * 14'(slot);
    assign ramp = prod[13:2];
    assign peak = {amp_q, 4'b0000};

    // Tail step is at least 1; compare in 13 bits so a small y never wraps
    logic [11:0] shr;
    logic [11:0] dec;
    logic [12:0] lim;
    logic        tail_end;
    logic [11:0] tail;

    assign shr      = y_q >> DECAY_SHIFT;
    assign dec      = (shr == 12'd0) ? 12'd1 : shr;
    assign lim      = {1'b0, dec} + 13'(TAIL_MIN);
    assign tail_end = ({1'b0, y_q} < lim);
    assign tail     = y_q - dec;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tim_d   = tim_q;
        frac_d  = frac_q;
        amp_d   = amp_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rej_d   = start && (state_q != S_IDLE);
        exp_d   = exp_q;
        unique case (state_q)
            S_IDLE: begin
                y_d = 12'd0;
                if (start) begin
                    tim_d   = tgt_tim;
                    frac_d  = tgt_frac;
                    amp_d   = amp;
                    exp_d   = {tgt_tim, tgt_frac};
                    k_d     = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (timcnt == tim_q) begin
                    y_d     = ramp;
                    k_d     = 2'd1;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                y_d = ramp;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_PEAK;
                end
            end
            S_PEAK: begin
                y_d     = peak;
                state_d = S_DECAY;
            end
            S_DECAY: begin
                if (tail_end) begin
                    y_d     = 12'd0;
                    state_d = S_FIN;
                end else begin
                    y_d = tail;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                y_d     = 12'd0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            tim_q   <= 8'd0;
            frac_q  <= 4'd0;
            amp_q   <= 8'd0;
            y_q     <= 12'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            exp_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tim_q   <= tim_d;
            frac_q  <= frac_d;
            amp_q   <= amp_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
            exp_q   <= exp_d;
        end
    end

`ifdef DYNODE_PULSEGEN_NOISE_EN
    // Noise rides on the output only; the tail arithmetic uses the clean y
    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;
    logic [13:0] noisy;
    logic [11:0] noisy_d, noisy_q;

    assign fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_d = {fb, lfsr_q[15:1]};
    assign noisy  = {2'b00, y_d} + {{11{lfsr_q[2]}}, lfsr_q[2:0]};

    always_comb begin
        noisy_d = noisy[11:0];
        if (noisy[13]) begin
            noisy_d = 12'd0;
        end else if (noisy[12]) begin
            noisy_d = 12'hFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= 16'hACE1;
            noisy_q <= 12'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            noisy_q <= noisy_d;
        end
    end

    assign dyn_sim = noisy_q;
`else
    assign dyn_sim = y_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign start_rej = rej_q;
    assign exp_tim   = exp_q;

endmodule

// File: tb/tb_dynode_pulsegen.sv
// Directed bench for dynode_pulsegen (default build, noise disabled).
module tb_dynode_pulsegen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  timcnt = 8'd0;
    logic        start = 1'b0;
    logic [7:0]  tgt_tim = 8'd0;
    logic [3:0]  tgt_frac = 4'd0;
    logic [7:0]  amp = 8'd0;
    logic [11:0] dyn_sim;
    logic        busy;
    logic        done;
    logic        start_rej;
    logic [11:0] exp_tim;

    int nvec = 0;
    int nerr = 0;

    dynode_pulsegen #(
        .DECAY_SHIFT(2),
        .TAIL_MIN(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .timcnt(timcnt),
        .start(start),
        .tgt_tim(tgt_tim),
        .tgt_frac(tgt_frac),
        .amp(amp),
        .dyn_sim(dyn_sim),
        .busy(busy),
        .done(done),
        .start_rej(start_rej),
        .exp_tim(exp_tim)
    );

    always #5 clk = ~clk;

    always @(posedge clk) timcnt <= timcnt + 8'd1;

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Call on a negedge; returns on the negedge after the accept edge
    task automatic issue(input logic [7:0] at, input logic [7:0] tt,
                         input logic [3:0] ff, input logic [7:0] aa);
        for (int i = 0; i < 300 && timcnt != at; i++) @(negedge clk);
        check("issue_timcnt", int'(timcnt), int'(at));
        tgt_tim  = tt;
        tgt_frac = ff;
        amp      = aa;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check("acc_busy", int'(busy), 1);
        check("acc_rej", int'(start_rej), 0);
        check("acc_dyn", int'(dyn_sim), 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns on the negedge just before the matching edge
    task automatic wait_match(input logic [7:0] tt);
        for (int i = 0; i < 300 && timcnt != tt; i++) @(negedge clk);
        check("match_timcnt", int'(timcnt), int'(tt));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 400);
        check("done_seen", int'(done), 1);
        check("done_busy", int'(busy), 0);
    endtask

    int ph0[22] = '{400, 800, 1200, 1600, 1600, 1200, 900, 675, 507, 381, 286,
                    215, 162, 122, 92, 69, 52, 39, 30, 23, 18, 0};
    int ph8[5]  = '{200, 600, 1000, 1400, 1600};

    initial begin
        int n;
        int nz;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dyn", int'(dyn_sim), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rej", int'(start_rej), 0);
        check("rst_exp", int'(exp_tim), 0);
        @(negedge clk);
        reset = 1'b0;

        // Phase 0 full waveform
        issue(8'h05, 8'h10, 4'd0, 8'd100);
        check("ph0_exp", int'(exp_tim), 12'h100);
        wait_match(8'h10);
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ph0_s%0d", i), int'(dyn_sim), ph0[i]);
            check($sformatf("ph0_busy%0d", i), int'(busy), 1);
        end
        @(posedge clk);
        #1;
        check("ph0_done", int'(done), 1);
        check("ph0_busy_end", int'(busy), 0);
        check("ph0_dyn_end", int'(dyn_sim), 0);
        @(posedge clk);
        #1;
        check("ph0_done_1cyc", int'(done), 0);
        @(negedge clk);

        // Phase 8 ramp, then a rejected start in DECAY
        issue(8'h20, 8'h40, 4'd8, 8'd100);
        check("ph8_exp", int'(exp_tim), 12'h408);
        wait_match(8'h40);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ph8_s%0d", i), int'(dyn_sim), ph8[i]);
        end
        @(negedge clk);
        tgt_tim  = 8'h77;
        tgt_frac = 4'd5;
        amp      = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check("rej_pulse", int'(start_rej), 1);
        check("rej_dyn", int'(dyn_sim), 1200);
        check("rej_exp", int'(exp_tim), 12'h408);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rej_clear", int'(start_rej), 0);
        check("rej_dyn2", int'(dyn_sim), 900);
        wait_done(n);
        check("rej_exp_end", int'(exp_tim), 12'h408);
        @(negedge clk);

        // Match in the accept cycle is ignored: one full wrap
        issue(8'h2F, 8'h2F, 4'd0, 8'd16);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dyn_sim == 12'd0 && n < 300);
        check("wrap_lat", n, 256);
        check("wrap_s0", int'(dyn_sim), 64);
        wait_done(n);
        @(negedge clk);

        // Target 0 issued at 0xFE
        issue(8'hFE, 8'h00, 4'd3, 8'd50);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dyn_sim == 12'd0 && n < 300);
        check("wrap2_timcnt", int'(timcnt), 1);
        check("wrap2_s0", int'(dyn_sim), 162);
        @(posedge clk);
        #1;
        check("wrap2_s1", int'(dyn_sim), 362);
        wait_done(n);
        @(negedge clk);

        // Zero amplitude
        issue(8'h60, 8'h70, 4'd0, 8'd0);
        wait_match(8'h70);
        n  = 0;
        nz = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (dyn_sim != 12'd0) nz++;
        end while (!done && n < 50);
        check("amp0_done_lat", n, 7);
        check("amp0_nonzero", nz, 0);
        @(negedge clk);

        // Reset during RISE
        issue(8'h80, 8'h88, 4'd0, 8'd100);
        wait_match(8'h88);
        @(posedge clk);
        #1;
        check("mrst_s0", int'(dyn_sim), 400);
        @(posedge clk);
        #1;
        check("mrst_s1", int'(dyn_sim), 800);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_dyn", int'(dyn_sim), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_rej", int'(start_rej), 0);
        check("mrst_exp", int'(exp_tim), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mrst_idle_dyn", int'(dyn_sim), 0);
        check("mrst_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
